// File: rtl/bpc_decoder.sv
// Stochastic-to-binary decoder for bit-plane-counter SNG streams.
// Counts ones on N parallel streams over a 2^p-sample prefix. It then
// scales each count up to W bits, saturating at the top, and hands the
// results to the binary domain over a valid/ready handshake.
module bpc_decoder #(
  parameter int W  = 8,
  parameter int N  = 1,
  parameter int PW = $clog2(W + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [PW-1:0] prec,
  input  logic          in_valid,
  input  logic [N-1:0]  Xs,
  output logic [W-1:0]  Bzs [N-1:0],
  output logic          out_valid,
  input  logic          out_ready,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE, COUNT, HOLD} state_t;

  state_t        state_q;
  logic [PW-1:0] p_q;
  logic [PW-1:0] p_d;
  logic [W:0]    len_q;
  logic [W:0]    len_d;
  logic [W:0]    target_len;
  logic [PW-1:0] shamt;
  logic          out_valid_q;
  logic          busy_q;

  // Counters are W+1 bits wide so a full 2^W run of ones fits without wrapping.
  logic [W:0]    ones_q   [N-1:0];
  logic [W:0]    ones_d   [N-1:0];
  logic [W:0]    shifted  [N-1:0];
  logic [W-1:0]  bz_new   [N-1:0];
  logic [W-1:0]  bzs_q    [N-1:0];

  // Precision clamp, run-length target and scale factor for the current run.
  always_comb begin
    p_d        = ((prec == '0) || (prec > PW'(W))) ? PW'(W) : prec;
    len_d      = len_q + (W+1)'(1);
    target_len = (W+1)'(1) << p_q;
    shamt      = PW'(W) - p_q;
  end

  // Per-stream next count and scaled result.
  // The scaled value reaches 2^W only for an all-ones stream, so that case saturates.
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_stream
      assign ones_d[gi]  = ones_q[gi] + (W+1)'(Xs[gi]);
      assign shifted[gi] = ones_d[gi] << shamt;
      assign bz_new[gi]  = shifted[gi][W] ? {W{1'b1}} : shifted[gi][W-1:0];
      assign Bzs[gi]     = bzs_q[gi];
    end
  endgenerate

  assign out_valid = out_valid_q;
  assign busy      = busy_q;

  // Control FSM with registered outputs.
  // A start-cycle sample is never counted; the first counted sample comes in the cycle after start.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      p_q         <= '0;
      len_q       <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      for (int i = 0; i < N; i++) begin
        ones_q[i] <= '0;
        bzs_q[i]  <= '0;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            p_q     <= p_d;
            len_q   <= '0;
            for (int i = 0; i < N; i++) ones_q[i] <= '0;
            busy_q  <= 1'b1;
            state_q <= COUNT;
          end
        end
        COUNT: begin
          if (in_valid) begin
            len_q <= len_d;
            for (int i = 0; i < N; i++) ones_q[i] <= ones_d[i];
            if (len_d == target_len) begin
              for (int i = 0; i < N; i++) bzs_q[i] <= bz_new[i];
              out_valid_q <= 1'b1;
              state_q     <= HOLD;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bpc_decoder.sv
// Directed bench for bpc_decoder (W=8, N=2).
// A table of runs is followed by hand-written backpressure and reset sequences.
module tb_bpc_decoder;

  localparam int W  = 8;
  localparam int N  = 2;
  localparam int PW = $clog2(W + 1);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [PW-1:0] prec;
  logic          in_valid;
  logic [N-1:0]  Xs;
  logic [W-1:0]  Bzs [N-1:0];
  logic          out_valid;
  logic          out_ready;
  logic          busy;

  int nchk = 0;
  int nerr = 0;

  bpc_decoder #(.W(W), .N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .prec      (prec),
    .in_valid  (in_valid),
    .Xs        (Xs),
    .Bzs       (Bzs),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Stream pattern codes: 0 zeros, 1 ones, 2 alternating 1,0, 3 first k ones, 4 bit k of mask.
  typedef struct {
    int prec;
    int nsamp;
    int gap;
    int code0;
    int code1;
    int karg0;
    int exp0;
    int exp1;
    int exp_lat;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic pat(input int code, input int k, input int karg);
    case (code)
      1:       return 1'b1;
      2:       return (k % 2) == 0;
      3:       return k < karg;
      4:       return ((karg >> k) & 1) != 0;
      default: return 1'b0;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start a run and feed samples until out_valid, then check latency and results.
  task automatic run_to_hold(input vec_t v, input string tag);
    int cyc;
    int vcount;
    start    = 1'b1;
    prec     = PW'(v.prec);
    in_valid = 1'b1;
    Xs       = '1;       // must not be counted
    tick();
    start = 1'b0;
    chk({tag, "_busy_after_start"}, int'(busy), 1);
    cyc    = 1;
    vcount = 0;
    while (!out_valid && cyc < 2000) begin
      if (v.gap != 0 && (cyc % 3) == 0) begin
        in_valid = 1'b0;
        Xs       = '1;
      end else if (vcount < v.nsamp) begin
        in_valid = 1'b1;
        Xs[0]    = pat(v.code0, vcount, v.karg0);
        Xs[1]    = pat(v.code1, vcount, 0);
        vcount++;
      end else begin
        in_valid = 1'b1;
        Xs       = '1;
      end
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    chk({tag, "_latency"}, cyc, v.exp_lat);
    chk({tag, "_bz0"}, int'(Bzs[0]), v.exp0);
    chk({tag, "_bz1"}, int'(Bzs[1]), v.exp1);
    $display("run %s prec=%0d latency=%0d Bzs0=%0d Bzs1=%0d", tag, v.prec, cyc, Bzs[0], Bzs[1]);
  endtask

  task automatic handshake(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_ov_after_hs"}, int'(out_valid), 0);
    chk({tag, "_busy_after_hs"}, int'(busy), 0);
  endtask

  initial begin
    vec_t bp;
    vec_t rv;
    logic [W-1:0] held0;
    logic [W-1:0] held1;

    // prec nsamp gap c0 c1 karg  e0  e1  lat
    vecs[0] = '{8, 256, 0, 1, 2, 0,  255, 128, 257};   // full run, saturation
    vecs[1] = '{4, 16,  0, 3, 0, 5,   80,   0,  17};   // early termination
    vecs[2] = '{8, 256, 1, 1, 2, 0,  255, 128, 384};   // gapped input
    vecs[3] = '{0, 256, 0, 3, 0, 64,  64,   0, 257};   // clamp prec=0
    vecs[4] = '{12, 256, 0, 3, 0, 64, 64,   0, 257};   // clamp prec>W
    vecs[5] = '{1, 2,   0, 1, 2, 0,  255, 128,   3};   // minimum run

    rst_n = 1'b0; start = 1'b0; prec = '0; in_valid = 1'b0; Xs = '0; out_ready = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    chk("reset_busy", int'(busy), 0);
    chk("reset_ov", int'(out_valid), 0);
    chk("reset_bz0", int'(Bzs[0]), 0);
    chk("reset_bz1", int'(Bzs[1]), 0);
    $display("reset busy=%0d out_valid=%0d", busy, out_valid);

    for (int i = 0; i < 6; i++) begin
      run_to_hold(vecs[i], $sformatf("v%0d", i));
      handshake($sformatf("v%0d", i));
    end

    // Backpressure: inputs toggling while HOLD waits on out_ready.
    bp = '{3, 8, 0, 2, 1, 0, 128, 255, 9};
    run_to_hold(bp, "bp");
    held0 = Bzs[0];
    held1 = Bzs[1];
    for (int c = 0; c < 10; c++) begin
      start    = c[0];
      in_valid = ~c[0];
      Xs       = c[1:0];
      tick();
      chk("bp_ov_hold", int'(out_valid), 1);
      chk("bp_busy_hold", int'(busy), 1);
      chk("bp_bz0_hold", int'(Bzs[0]), 128);
      chk("bp_bz1_hold", int'(Bzs[1]), 255);
    end
    $display("backpressure held Bzs0=%0d Bzs1=%0d", held0, held1);
    start     = 1'b1;    // ignored on the handshake edge
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    start     = 1'b0;
    out_ready = 1'b0;
    chk("bp_ov_after_hs", int'(out_valid), 0);
    chk("bp_busy_after_hs", int'(busy), 0);
    chk("bp_bz0_retained", int'(Bzs[0]), 128);
    chk("bp_bz1_retained", int'(Bzs[1]), 255);
    tick();
    chk("bp_still_idle", int'(busy), 0);
    $display("backpressure released busy=%0d Bzs0=%0d", busy, Bzs[0]);

    // Reset in the middle of a run discards it.
    start = 1'b1; prec = PW'(8); in_valid = 1'b1; Xs = '1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 100; c++) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    in_valid = 1'b0;
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_ov", int'(out_valid), 0);
    chk("mid_rst_bz0", int'(Bzs[0]), 0);
    chk("mid_rst_bz1", int'(Bzs[1]), 0);
    $display("mid-run reset busy=%0d out_valid=%0d Bzs0=%0d", busy, out_valid, Bzs[0]);
    rv = '{2, 4, 0, 4, 0, 11, 192, 0, 5};     // Xs0 = 1,1,0,1
    run_to_hold(rv, "after_rst");
    handshake("after_rst");

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/bpc_decoder.md
# bpc_decoder

Stochastic-to-binary decoder paired with the bit-plane-counter SNG: it accumulates N parallel stochastic bitstreams and returns W-bit binary estimates. Early termination is supported at any power-of-two prefix length 2^prec. A bit-plane-counter SNG prefix of length 2^prec already carries prec-bit precision. The block sits at the output of the SC compute datapath and hands results to the binary domain over a valid/ready handshake.

## Interface
- W, 8, full precision in bits; full stream length 2^W.
- N, 1, number of parallel stochastic streams decoded together.
- PW, $clog2(W+1), width of the prec port (derived).
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  begin a decode run; honoured only in IDLE.
- prec  in  PW  early-termination precision, sampled with start.
- in_valid  in  1  Xs carries one valid stream bit per stream this cycle.
- Xs  in  N  stochastic bits, one per stream.
- Bzs  out  [W-1:0] x N (unpacked [N-1:0])  binary estimates, registered.
- out_valid  out  1  Bzs holds a completed result.
- out_ready  in  1  consumer accepts the result.
- busy  out  1  high whenever the state is not IDLE.

## Operation
- States: IDLE, COUNT, HOLD.
- IDLE:
  - start=1 latches p = prec, then moves to COUNT.
  - p is clamped: prec=0 or prec>W gives p=W.
  - The length counter and all N ones counters are cleared.
- COUNT:
  - Each cycle with in_valid=1, len increments by 1.
  - ones[i] increments by Xs[i].
  - Counter width is W+1 bits, so they never wrap for a length of 2^W.
  - Cycles with in_valid=0 change nothing.
  - When the accepted sample makes len equal to 2^p, the block computes Bzs[i] = min(ones[i] << (W-p), 2^W-1) for each stream and moves to HOLD.
  - The only saturating case is an all-ones stream.
- HOLD:
  - out_valid=1 and Bzs are stable.
  - out_valid && out_ready moves to IDLE.
- Ignored inputs:
  - start outside IDLE, including the HOLD handshake cycle.
  - in_valid/Xs in IDLE and HOLD.
  - prec except on the start cycle.
- Bzs keeps its last result after the handshake until the next result overwrites it.

## Timing
- Reset: state=IDLE, out_valid=0, busy=0, Bzs all 0, all counters 0.
  - Reset applies on the next edge from any state, including mid-COUNT and HOLD.
  - A partial run is discarded.
- Start cycle:
  - The start cycle's Xs is not counted.
  - The first countable sample is in the cycle after start.
  - busy=1 from the cycle after start.
- Latency:
  - out_valid and the new Bzs appear in the cycle after the 2^p-th accepted sample.
  - With in_valid held high, that is 2^p+1 cycles after start.
- Handshake:
  - The result is transferred on the edge where out_valid && out_ready.
  - out_valid=0 and busy=0 on the following cycle.
  - The earliest next start is in that IDLE cycle.
  - out_ready is ignored when out_valid=0.
- Minimum run with p=1: start, 2 samples, HOLD.

## Test plan
- Full-length run and saturation (W=8, N=2, prec=8, in_valid always 1).
  - Stream 0 all ones, stream 1 alternating 1,0.
  - Required: Bzs[0]=255 (saturated), Bzs[1]=128.
  - out_valid rises exactly 257 cycles after start.
- Early termination (prec=4).
  - Stream 0 has ones on 5 of 16 samples; stream 1 all zeros.
  - Required: Bzs[0]=80, Bzs[1]=0, out_valid 17 cycles after start.
  - Xs after the 16th sample has no effect.
- Gapped input (prec=8).
  - in_valid deasserted every third cycle, with Xs=1 driven during the gaps.
  - Required: result identical to test 1.
  - out_valid the cycle after the 256th valid sample.
- Backpressure (prec=3).
  - Hold out_ready=0 for 10 cycles in HOLD while toggling start, in_valid and Xs.
  - Required: out_valid and Bzs stable, busy=1.
  - After out_ready=1: IDLE next cycle with busy=0; the old Bzs is retained.
- Reset mid-run.
  - Assert rst_n=0 for one cycle after 100 samples.
  - Required next cycle: busy=0, out_valid=0, Bzs=0.
  - A new start with prec=2 and Xs=1,1,0,1 gives Bzs[0]=192.
- Clamping.
  - prec=0 and prec=12 (PW=4) each behave as prec=8.
  - Required: out_valid only after 256 samples; a 64-ones stream gives 64.
